// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, defaults and range check for the instruction memory arbiter
package imem_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_SIZE   = 64;
  localparam int DEF_MAX_WAIT   = 4;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } imem_state_t;

  // Callers zero-extend their address so one function serves any ADDR_WIDTH.
  function automatic logic out_of_range(input logic [63:0] addr, input int unsigned size);
    return addr >= 64'(size);
  endfunction

endpackage

// File: rtl/imem_port_resp.sv
// rtl/imem_port_resp.sv - one-cycle response register for a single requester port
module imem_port_resp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gnt,
  input  logic                  we,
  input  logic                  oor,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  exc
);

  logic rd_q;

  // Capture what the accepted access was; read data itself arrives from the synchronous memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      exc    <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      rvalid <= gnt;
      exc    <= gnt && oor;
      rd_q   <= gnt && !we && !oor;
    end
  end

  // Only an in-range read exposes memory data; writes and exceptions return zero.
  assign rdata = rd_q ? mem_rdata : '0;

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - fetch/loader arbiter and sequencer for the single-port instruction memory
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  output logic                  fetch_exc,
  input  logic                  load_req,
  input  logic                  load_we,
  input  logic                  load_lock,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  output logic                  load_gnt,
  output logic                  load_rvalid,
  output logic [DATA_WIDTH-1:0] load_rdata,
  output logic                  load_exc,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  imem_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_full;
  logic              fetch_oor;
  logic              load_oor;

  assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign fetch_oor = out_of_range(64'(fetch_addr), MEM_SIZE);
  assign load_oor  = out_of_range(64'(load_addr), MEM_SIZE);

  // Grant selection: fetch first unless the loader has waited long enough; a lock shuts fetch out.
  always_comb begin
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (!rst) begin
      if (state == OPEN) begin
        if (load_req && (wait_full || !fetch_req)) load_gnt = 1'b1;
        else                                       fetch_gnt = fetch_req;
      end else begin
        if (load_req)        load_gnt  = 1'b1;
        else if (!load_lock) fetch_gnt = fetch_req;
      end
    end
  end

  // Memory mux follows the fetch port unless the loader holds the grant; out-of-range never strobes.
  always_comb begin
    mem_addr  = load_gnt ? load_addr : fetch_addr;
    mem_wdata = load_gnt ? load_wdata : '0;
    mem_en    = (load_gnt && !load_oor) || (fetch_gnt && !fetch_oor);
    mem_we    = load_gnt && load_we && !load_oor;
  end

  // Lock FSM plus the loader starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OPEN;
      wait_cnt <= '0;
    end else begin
      case (state)
        OPEN:    if (load_gnt && load_lock) state <= LOCKED;
        LOCKED:  if (!load_lock)            state <= OPEN;
        default:                            state <= OPEN;
      endcase
      if (load_req && !load_gnt) begin
        if (!wait_full) wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  imem_port_resp #(.DATA_WIDTH(DATA_WIDTH)) u_fetch_resp (
    .clk       (clk),
    .rst       (rst),
    .gnt       (fetch_gnt),
    .we        (1'b0),
    .oor       (fetch_oor),
    .mem_rdata (mem_rdata),
    .rvalid    (fetch_rvalid),
    .rdata     (fetch_rdata),
    .exc       (fetch_exc)
  );

  imem_port_resp #(.DATA_WIDTH(DATA_WIDTH)) u_load_resp (
    .clk       (clk),
    .rst       (rst),
    .gnt       (load_gnt),
    .we        (load_we),
    .oor       (load_oor),
    .mem_rdata (mem_rdata),
    .rvalid    (load_rvalid),
    .rdata     (load_rdata),
    .exc       (load_exc)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - scoreboard bench for imem_arbiter
module tb_imem_arbiter;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid, fetch_exc;
  logic [15:0] fetch_rdata;
  logic        load_req, load_we, load_lock;
  logic [15:0] load_addr, load_wdata;
  logic        load_gnt, load_rvalid, load_exc;
  logic [15:0] load_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  logic        mem_init;
  logic [15:0] mem [0:63];

  int vectors = 0;
  int miscompares = 0;

  logic [16:0] fq[$];
  logic [16:0] lq[$];
  logic [16:0] fe, le;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_exc    (fetch_exc),
    .load_req     (load_req),
    .load_we      (load_we),
    .load_lock    (load_lock),
    .load_addr    (load_addr),
    .load_wdata   (load_wdata),
    .load_gnt     (load_gnt),
    .load_rvalid  (load_rvalid),
    .load_rdata   (load_rdata),
    .load_exc     (load_exc),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
      mem[5]  <= 16'hABCD;
      mem[10] <= 16'h5555;
      mem[36] <= 16'h3636;
      mem[63] <= 16'h6363;
      mem_rdata <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  always @(negedge clk) begin
    if (fetch_rvalid) begin
      vectors++;
      if (fq.size() == 0) begin
        miscompares++;
        $display("FAIL fetch_resp: unexpected rvalid exc=%0b rdata=%h, required no response", fetch_exc, fetch_rdata);
      end else begin
        fe = fq.pop_front();
        if ({fetch_exc, fetch_rdata} !== fe) begin
          miscompares++;
          $display("FAIL fetch_resp: got exc=%0b rdata=%h, required exc=%0b rdata=%h", fetch_exc, fetch_rdata, fe[16], fe[15:0]);
        end
      end
    end
    if (load_rvalid) begin
      vectors++;
      if (lq.size() == 0) begin
        miscompares++;
        $display("FAIL load_resp: unexpected rvalid exc=%0b rdata=%h, required no response", load_exc, load_rdata);
      end else begin
        le = lq.pop_front();
        if ({load_exc, load_rdata} !== le) begin
          miscompares++;
          $display("FAIL load_resp: got exc=%0b rdata=%h, required exc=%0b rdata=%h", load_exc, load_rdata, le[16], le[15:0]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  task automatic step(input string n,
                      input logic fr, input logic [15:0] fa,
                      input logic lr, input logic lw, input logic ll,
                      input logic [15:0] la, input logic [15:0] ld,
                      input logic efg, input logic elg, input logic een, input logic ewe,
                      input logic [16:0] ef, input logic [16:0] el);
    fetch_req  = fr;
    fetch_addr = fa;
    load_req   = lr;
    load_we    = lw;
    load_lock  = ll;
    load_addr  = la;
    load_wdata = ld;
    @(negedge clk);
    chk({n, " fetch_gnt"}, 32'(fetch_gnt), 32'(efg));
    chk({n, " load_gnt"},  32'(load_gnt),  32'(elg));
    chk({n, " mem_en"},    32'(mem_en),    32'(een));
    chk({n, " mem_we"},    32'(mem_we),    32'(ewe));
    if (efg) fq.push_back(ef);
    if (elg) lq.push_back(el);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    fetch_req = 1'b1; fetch_addr = 16'd5;
    load_req = 1'b0; load_we = 1'b0; load_lock = 1'b0;
    load_addr = 16'd0; load_wdata = 16'd0;

    @(negedge clk);
    chk("reset fetch_gnt", 32'(fetch_gnt), 32'd0);
    chk("reset load_gnt", 32'(load_gnt), 32'd0);
    chk("reset fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("reset load_rvalid", 32'(load_rvalid), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset fetch_rdata", 32'(fetch_rdata), 32'd0);
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    step("fetch5",    1, 16'd5,   0, 0, 0, 16'd0,   16'h0000, 1, 0, 1, 0, {1'b0, 16'hABCD}, 17'h0);
    step("fetch63",   1, 16'd63,  0, 0, 0, 16'd0,   16'h0000, 1, 0, 1, 0, {1'b0, 16'h6363}, 17'h0);
    step("fetch64",   1, 16'd64,  0, 0, 0, 16'd0,   16'h0000, 1, 0, 0, 0, {1'b1, 16'h0000}, 17'h0);
    step("loadw100",  0, 16'd0,   1, 1, 0, 16'd100, 16'hBEEF, 0, 1, 0, 0, 17'h0, {1'b1, 16'h0000});
    step("fetch36",   1, 16'd36,  0, 0, 0, 16'd0,   16'h0000, 1, 0, 1, 0, {1'b0, 16'h3636}, 17'h0);
    step("loadr63",   0, 16'd0,   1, 0, 0, 16'd63,  16'h0000, 0, 1, 1, 0, 17'h0, {1'b0, 16'h6363});
    step("idle0",     0, 16'd0,   0, 0, 0, 16'd0,   16'h0000, 0, 0, 0, 0, 17'h0, 17'h0);

    for (int i = 0; i < 4; i++)
      step($sformatf("starve%0d", i), 1, 16'd5, 1, 0, 0, 16'd5, 16'h0000, 1, 0, 1, 0, {1'b0, 16'hABCD}, 17'h0);
    step("starve4",   1, 16'd5,   1, 0, 0, 16'd5,   16'h0000, 0, 1, 1, 0, 17'h0, {1'b0, 16'hABCD});
    chk("starve wait_cnt", 32'(dut.wait_cnt), 32'd0);
    step("idle1",     0, 16'd0,   0, 0, 0, 16'd0,   16'h0000, 0, 0, 0, 0, 17'h0, 17'h0);

    step("lockw0",    0, 16'd5,   1, 1, 1, 16'd0,   16'h1000, 0, 1, 1, 1, 17'h0, 17'h0);
    for (int i = 1; i < 4; i++)
      step($sformatf("lockw%0d", i), 1, 16'd5, 1, 1, 1, 16'(i), 16'h1000 + 16'(i), 0, 1, 1, 1, 17'h0, 17'h0);
    chk("lock state", 32'(dut.state), 32'(LOCKED));
    step("unlock_f2", 1, 16'd2,   0, 0, 0, 16'd0,   16'h0000, 1, 0, 1, 0, {1'b0, 16'h1002}, 17'h0);
    chk("unlock state", 32'(dut.state), 32'(OPEN));

    step("lockw4",    0, 16'd0,   1, 1, 1, 16'd4,   16'h1004, 0, 1, 1, 1, 17'h0, 17'h0);
    step("unlock_r3", 1, 16'd4,   1, 0, 0, 16'd3,   16'h0000, 0, 1, 1, 0, 17'h0, {1'b0, 16'h1003});
    step("fetch4",    1, 16'd4,   0, 0, 0, 16'd0,   16'h0000, 1, 0, 1, 0, {1'b0, 16'h1004}, 17'h0);

    // Granted read whose response is killed by reset; no expectation pushed.
    fetch_req = 1'b1; fetch_addr = 16'd7; load_req = 1'b0;
    @(negedge clk);
    chk("midrst fetch_gnt", 32'(fetch_gnt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    fetch_req = 1'b0;
    load_req = 1'b1; load_we = 1'b1; load_lock = 1'b0; load_addr = 16'd10; load_wdata = 16'hDEAD;
    @(negedge clk);
    chk("midrst fetch_rvalid", 32'(fetch_rvalid), 32'd0);
    chk("midrst load_gnt", 32'(load_gnt), 32'd0);
    chk("midrst mem_en", 32'(mem_en), 32'd0);
    chk("midrst mem_we", 32'(mem_we), 32'd0);
    chk("midrst state", 32'(dut.state), 32'(OPEN));
    @(posedge clk); #1;
    rst = 1'b0;
    step("fetch10",   1, 16'd10,  0, 0, 0, 16'd0,   16'h0000, 1, 0, 1, 0, {1'b0, 16'h5555}, 17'h0);
    step("idle2",     0, 16'd0,   0, 0, 0, 16'd0,   16'h0000, 0, 0, 0, 0, 17'h0, 17'h0);
    step("idle3",     0, 16'd0,   0, 0, 0, 16'd0,   16'h0000, 0, 0, 0, 0, 17'h0, 17'h0);

    chk("fetch queue drained", 32'(fq.size()), 32'd0);
    chk("load queue drained", 32'(lq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
